// File: rtl/tank_pkg.sv
// Shared types, arena defaults and fixed-point helpers for the tank projectile datapath.
package tank_pkg;

    typedef logic [13:0] fix14_t;

    typedef struct packed {
        logic       neg;
        logic [7:0] mag;
    } sm9_t;

    localparam int unsigned ANGLE_STEPS  = 90;
    localparam logic [6:0]  HALF_TURN    = 7'(ANGLE_STEPS / 2);
    // Last angle step that still lies below 90 degrees.
    localparam logic [6:0]  QUARTER_TURN = 7'(ANGLE_STEPS / 4);

    localparam logic [9:0] ARENA_MIN_X_DEF = 10'd8;
    localparam logic [9:0] ARENA_MAX_X_DEF = 10'd631;
    localparam logic [9:0] ARENA_MIN_Y_DEF = 10'd8;
    localparam logic [9:0] ARENA_MAX_Y_DEF = 10'd471;

    function automatic logic signed [15:0] fix_step(fix14_t pos, sm9_t vel);
        logic signed [15:0] p;
        logic signed [15:0] m;
        p = signed'({2'b00, pos});
        m = signed'({8'h00, vel.mag});
        return vel.neg ? (p - m) : (p + m);
    endfunction

    function automatic logic fix_outside(logic signed [15:0] nxt, logic [9:0] lo, logic [9:0] hi);
        logic signed [15:0] lo_f;
        logic signed [15:0] hi_f;
        lo_f = signed'({2'b00, lo, 4'h0});
        hi_f = signed'({2'b00, hi, 4'hF});
        return (nxt < lo_f) || (nxt > hi_f);
    endfunction

endpackage

// File: rtl/tank_bullets_if.sv
// Keyboard/tank inputs, hit strobes and bullet outputs of the projectile pool.
interface tank_bullets_if #(
    parameter int unsigned NUM_BULLETS = 4
);
    logic [7:0]                  port_0;
    logic [7:0]                  port_1;
    logic [7:0]                  port_2;
    logic [7:0]                  port_3;
    logic [7:0]                  port_4;
    logic [7:0]                  port_5;
    logic [9:0]                  tank_x;
    logic [9:0]                  tank_y;
    logic [6:0]                  tank_angle;
    logic [NUM_BULLETS-1:0]      hit;
    logic [NUM_BULLETS-1:0]      bullet_active;
    logic [NUM_BULLETS-1:0][9:0] bullet_x;
    logic [NUM_BULLETS-1:0][9:0] bullet_y;
    logic                        fire_event;

    modport master (
        output port_0, port_1, port_2, port_3, port_4, port_5,
        output tank_x, tank_y, tank_angle, hit,
        input  bullet_active, bullet_x, bullet_y, fire_event
    );

    modport slave (
        input  port_0, port_1, port_2, port_3, port_4, port_5,
        input  tank_x, tank_y, tank_angle, hit,
        output bullet_active, bullet_x, bullet_y, fire_event
    );

endinterface

// File: rtl/bullet_slot.sv
// One projectile slot: spawn load, per-frame move with wall reflection, ageing and retirement.
module bullet_slot
    import tank_pkg::*;
#(
    parameter logic [9:0] LIFE        = 10'd300,
    parameter logic [9:0] ARENA_MIN_X = ARENA_MIN_X_DEF,
    parameter logic [9:0] ARENA_MAX_X = ARENA_MAX_X_DEF,
    parameter logic [9:0] ARENA_MIN_Y = ARENA_MIN_Y_DEF,
    parameter logic [9:0] ARENA_MAX_Y = ARENA_MAX_Y_DEF
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       i_spawn,
    input  fix14_t     i_spawn_x,
    input  fix14_t     i_spawn_y,
    input  sm9_t       i_spawn_vx,
    input  sm9_t       i_spawn_vy,
    input  logic       i_hit,
    output logic       o_active,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    logic               r_active;
    fix14_t             r_x;
    fix14_t             r_y;
    sm9_t               r_vx;
    sm9_t               r_vy;
    logic [9:0]         r_life;
    logic signed [15:0] w_next_x;
    logic signed [15:0] w_next_y;
    logic               w_out_x;
    logic               w_out_y;

    assign w_next_x = fix_step(r_x, r_vx);
    assign w_next_y = fix_step(r_y, r_vy);
    assign w_out_x  = fix_outside(w_next_x, ARENA_MIN_X, ARENA_MAX_X);
    assign w_out_y  = fix_outside(w_next_y, ARENA_MIN_Y, ARENA_MAX_Y);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_vx     <= '0;
            r_vy     <= '0;
            r_life   <= '0;
        end else if (i_spawn) begin
            r_active <= 1'b1;
            r_x      <= i_spawn_x;
            r_y      <= i_spawn_y;
            r_vx     <= i_spawn_vx;
            r_vy     <= i_spawn_vy;
            r_life   <= LIFE;
        end else if (r_active) begin
            if (i_hit || (r_life == 10'd1)) begin
                r_active <= 1'b0;
            end else begin
                r_life <= r_life - 10'd1;
                // A wall bounce holds that axis for this frame and reverses its direction.
                if (w_out_x) r_vx.neg <= ~r_vx.neg;
                else         r_x      <= w_next_x[13:0];
                if (w_out_y) r_vy.neg <= ~r_vy.neg;
                else         r_y      <= w_next_y[13:0];
            end
        end
    end

    assign o_active = r_active;
    assign o_x      = r_x[13:4];
    assign o_y      = r_y[13:4];

endmodule

// File: rtl/tank_trig.sv
// Angle step (4 degrees each) to sign-magnitude sin/cos with amplitude 16.
module tank_trig
    import tank_pkg::*;
(
    input  logic [6:0] i_angle,
    output sm9_t       o_sin,
    output sm9_t       o_cos
);

    logic       w_lower;
    logic [6:0] w_half;
    logic       w_obtuse;
    logic [6:0] w_fold;
    logic [4:0] w_sin_mag;
    logic [4:0] w_cos_mag;

    // Fold into the first quadrant; sin sign follows the half-turn, cos sign the obtuse fold.
    always_comb begin
        w_lower  = (i_angle >= HALF_TURN);
        w_half   = w_lower ? (i_angle - HALF_TURN) : i_angle;
        w_obtuse = (w_half > QUARTER_TURN);
        w_fold   = w_obtuse ? (HALF_TURN - w_half) : w_half;
        {w_sin_mag, w_cos_mag} = 10'd0;
        case (w_fold)
            7'd0:  {w_sin_mag, w_cos_mag} = {5'd0,  5'd16};
            7'd1:  {w_sin_mag, w_cos_mag} = {5'd1,  5'd16};
            7'd2:  {w_sin_mag, w_cos_mag} = {5'd2,  5'd16};
            7'd3:  {w_sin_mag, w_cos_mag} = {5'd3,  5'd16};
            7'd4:  {w_sin_mag, w_cos_mag} = {5'd4,  5'd15};
            7'd5:  {w_sin_mag, w_cos_mag} = {5'd5,  5'd15};
            7'd6:  {w_sin_mag, w_cos_mag} = {5'd7,  5'd15};
            7'd7:  {w_sin_mag, w_cos_mag} = {5'd8,  5'd14};
            7'd8:  {w_sin_mag, w_cos_mag} = {5'd8,  5'd14};
            7'd9:  {w_sin_mag, w_cos_mag} = {5'd9,  5'd13};
            7'd10: {w_sin_mag, w_cos_mag} = {5'd10, 5'd12};
            7'd11: {w_sin_mag, w_cos_mag} = {5'd11, 5'd12};
            7'd12: {w_sin_mag, w_cos_mag} = {5'd12, 5'd11};
            7'd13: {w_sin_mag, w_cos_mag} = {5'd13, 5'd10};
            7'd14: {w_sin_mag, w_cos_mag} = {5'd13, 5'd9};
            7'd15: {w_sin_mag, w_cos_mag} = {5'd14, 5'd8};
            7'd16: {w_sin_mag, w_cos_mag} = {5'd14, 5'd7};
            7'd17: {w_sin_mag, w_cos_mag} = {5'd15, 5'd6};
            7'd18: {w_sin_mag, w_cos_mag} = {5'd15, 5'd5};
            7'd19: {w_sin_mag, w_cos_mag} = {5'd16, 5'd4};
            7'd20: {w_sin_mag, w_cos_mag} = {5'd16, 5'd3};
            7'd21: {w_sin_mag, w_cos_mag} = {5'd16, 5'd2};
            7'd22: {w_sin_mag, w_cos_mag} = {5'd16, 5'd1};
            default: {w_sin_mag, w_cos_mag} = 10'd0;
        endcase
    end

    assign o_sin = {w_lower && (w_sin_mag != 5'd0), 3'b000, w_sin_mag};
    assign o_cos = {(w_obtuse ^ w_lower) && (w_cos_mag != 5'd0), 3'b000, w_cos_mag};

endmodule

// File: rtl/tank_bullets.sv
// Per-tank projectile pool: fire edge detect, cooldown, free-slot pick, trig and the slot array.
module tank_bullets
    import tank_pkg::*;
#(
    parameter int unsigned NUM_BULLETS = 4,
    parameter logic [9:0]  LIFE        = 10'd300,
    parameter logic [5:0]  COOLDOWN    = 6'd15,
    parameter logic [7:0]  FIRE_KEY    = 8'h2C,
    parameter logic [9:0]  ARENA_MIN_X = ARENA_MIN_X_DEF,
    parameter logic [9:0]  ARENA_MAX_X = ARENA_MAX_X_DEF,
    parameter logic [9:0]  ARENA_MIN_Y = ARENA_MIN_Y_DEF,
    parameter logic [9:0]  ARENA_MAX_Y = ARENA_MAX_Y_DEF
) (
    input logic           frame_clk,
    input logic           Reset,
    tank_bullets_if.slave bus
);

    logic                        w_fire_now;
    logic                        r_fire_prev;
    logic [5:0]                  r_cooldown;
    logic                        r_fire_event;
    logic                        w_free;
    logic                        w_spawn;
    logic [NUM_BULLETS-1:0]      w_target;
    logic [NUM_BULLETS-1:0]      w_active;
    logic [NUM_BULLETS-1:0][9:0] w_bx;
    logic [NUM_BULLETS-1:0][9:0] w_by;
    sm9_t                        w_sin;
    sm9_t                        w_cos;
    logic [7:0]                  w_vx_mag;
    logic [7:0]                  w_vy_mag;
    sm9_t                        w_vx;
    sm9_t                        w_vy;

    assign w_fire_now = (bus.port_0 == FIRE_KEY) || (bus.port_1 == FIRE_KEY) ||
                        (bus.port_2 == FIRE_KEY) || (bus.port_3 == FIRE_KEY) ||
                        (bus.port_4 == FIRE_KEY) || (bus.port_5 == FIRE_KEY);

    // Lowest-index free slot, judged on occupancy before this edge's hits and expiries.
    always_comb begin
        w_target = '0;
        w_free   = 1'b0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (!w_active[i] && !w_free) begin
                w_target[i] = 1'b1;
                w_free      = 1'b1;
            end
        end
    end

    assign w_spawn = w_fire_now && !r_fire_prev && (r_cooldown == 6'd0) && w_free;

    tank_trig u_trig (
        .i_angle (bus.tank_angle),
        .o_sin   (w_sin),
        .o_cos   (w_cos)
    );

    // Screen y grows downward, so a positive sine means a negative y step.
    assign w_vx_mag = w_cos.mag << 2;
    assign w_vy_mag = w_sin.mag << 2;
    assign w_vx     = {w_cos.neg && (w_vx_mag != 8'd0), w_vx_mag};
    assign w_vy     = {!w_sin.neg && (w_vy_mag != 8'd0), w_vy_mag};

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_fire_prev  <= 1'b1;
            r_cooldown   <= '0;
            r_fire_event <= 1'b0;
        end else begin
            r_fire_prev  <= w_fire_now;
            r_fire_event <= w_spawn;
            if (w_spawn)                  r_cooldown <= COOLDOWN;
            else if (r_cooldown != 6'd0) r_cooldown <= r_cooldown - 6'd1;
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .LIFE        (LIFE),
            .ARENA_MIN_X (ARENA_MIN_X),
            .ARENA_MAX_X (ARENA_MAX_X),
            .ARENA_MIN_Y (ARENA_MIN_Y),
            .ARENA_MAX_Y (ARENA_MAX_Y)
        ) u_slot (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .i_spawn    (w_spawn && w_target[g]),
            .i_spawn_x  ({bus.tank_x, 4'h0}),
            .i_spawn_y  ({bus.tank_y, 4'h0}),
            .i_spawn_vx (w_vx),
            .i_spawn_vy (w_vy),
            .i_hit      (bus.hit[g]),
            .o_active   (w_active[g]),
            .o_x        (w_bx[g]),
            .o_y        (w_by[g])
        );
    end

    assign bus.bullet_active = w_active;
    assign bus.bullet_x      = w_bx;
    assign bus.bullet_y      = w_by;
    assign bus.fire_event    = r_fire_event;

endmodule
